// File: rtl/saturn_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : saturn_bus_pkg
// Brief   : Shared bus command codes, FSM states and sizing constants.
// Revision: 1.0
// ============================================================================
package saturn_bus_pkg;

    localparam int ADDR_W    = 20;
    localparam int MAX_NIB   = 16;
    localparam int LOAD_NIBS = ADDR_W / 4;

    typedef enum logic [3:0] {
        BUS_NOP      = 4'd0,
        BUS_PC_READ  = 4'd1,
        BUS_DP_READ  = 4'd2,
        BUS_DP_WRITE = 4'd3,
        BUS_LOAD_PC  = 4'd4,
        BUS_LOAD_DP  = 4'd5
    } bus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_ADDR = 2'd1,
        ST_XFER      = 2'd2,
        ST_RESP      = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/saturn_bus_ptr.sv
`default_nettype none
// ============================================================================
// Module  : saturn_bus_ptr
// Brief   : Bus-side address pointer mirror (nibble shift-in load, increment).
// Revision: 1.0
// ============================================================================
module saturn_bus_ptr
    import saturn_bus_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_load_last,
    input  logic [3:0]        i_load_nib,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_cmp_addr,
    output logic              o_match
);

    localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_ptr;
    logic              r_valid;

    // Load nibbles arrive low first, so shift them in from the top.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ptr   <= {i_load_nib, r_ptr[ADDR_W-1:4]};
            r_valid <= i_load_last;
        end else if (i_inc) begin
            r_ptr   <= r_ptr + C_ONE;
        end
    end

    assign o_match = r_valid && (r_ptr == i_cmp_addr);

endmodule
`default_nettype wire

// File: rtl/saturn_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : saturn_bus_ctrl
// Brief   : Arbitrates fetch and data transfers onto the HP48 nibble bus.
// Revision: 1.0
// ============================================================================
module saturn_bus_ctrl
    import saturn_bus_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en_bus_send,
    input  logic              i_en_bus_recv,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [3:0]        o_fetch_nibble,
    output logic              o_fetch_valid,
    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [3:0]        i_data_len,
    input  logic [63:0]       i_data_wdata,
    output logic [63:0]       o_data_rdata,
    output logic              o_data_done,
    output logic              o_stall_dec,
    output logic              o_bus_strobe,
    output logic [3:0]        o_bus_cmd,
    output logic [3:0]        o_bus_nibble_out,
    input  logic [3:0]        i_bus_nibble_in
);

    bus_state_t        r_state, w_next;
    logic              r_dp, r_we, r_rd_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [63:0]       r_wdata, r_rdata;
    logic [4:0]        r_idx;
    logic [2:0]        r_load_cnt;
    logic [3:0]        r_fetch_nib, r_nib_out;
    logic              r_fetch_valid, r_done, r_stall, r_strobe;
    bus_cmd_t          r_cmd;

    logic              w_accept, w_hit, w_pc_match, w_dp_match;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_cur_dp, w_cur_we;
    logic [3:0]        w_cur_len, w_cur_idx, w_nib, w_rd_idx;
    logic [63:0]       w_cur_wdata;
    logic              w_issue, w_load, w_load_last, w_finish;
    bus_cmd_t          w_cmd;

    assign w_req_addr = i_data_req ? i_data_addr : i_pc;
    assign w_accept   = (r_state == ST_IDLE) && i_en_bus_send && (i_data_req || i_fetch_req);
    assign w_hit      = i_data_req ? w_dp_match : w_pc_match;
    assign w_rd_idx   = r_idx[3:0] - 4'd1;
    assign w_finish   = (w_next == ST_RESP) && (r_state != ST_RESP);

    saturn_bus_ptr u_pc_ptr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load && !r_dp),
        .i_load_last (w_load_last),
        .i_load_nib  (w_nib),
        .i_inc       (w_issue && !w_cur_dp),
        .i_cmp_addr  (w_req_addr),
        .o_match     (w_pc_match)
    );

    saturn_bus_ptr u_dp_ptr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load && r_dp),
        .i_load_last (w_load_last),
        .i_load_nib  (w_nib),
        .i_inc       (w_issue && w_cur_dp),
        .i_cmp_addr  (w_req_addr),
        .o_match     (w_dp_match)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // In IDLE the "current" transfer is the incoming request, so a pointer hit
    // can issue its first command on the accepting strobe.
    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_cmd       = BUS_NOP;
        w_nib       = 4'h0;
        w_cur_dp    = r_dp;
        w_cur_we    = r_we;
        w_cur_len   = r_len;
        w_cur_idx   = r_idx[3:0];
        w_cur_wdata = r_wdata;
        case (r_state)
            ST_IDLE: begin
                w_cur_dp    = i_data_req;
                w_cur_we    = i_data_req && i_data_we;
                w_cur_len   = i_data_req ? i_data_len : 4'd0;
                w_cur_idx   = 4'd0;
                w_cur_wdata = i_data_wdata;
                if (w_accept) begin
                    if (w_hit) begin
                        w_issue = 1'b1;
                        w_next  = (w_cur_we && (w_cur_len == 4'd0)) ? ST_RESP : ST_XFER;
                    end else begin
                        w_next  = ST_LOAD_ADDR;
                    end
                end
            end
            ST_LOAD_ADDR: begin
                if (i_en_bus_send) begin
                    w_load      = 1'b1;
                    w_load_last = (r_load_cnt == 3'(LOAD_NIBS - 1));
                    w_cmd       = r_dp ? BUS_LOAD_DP : BUS_LOAD_PC;
                    w_nib       = r_addr[{r_load_cnt, 2'b00} +: 4];
                    if (w_load_last) w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (i_en_bus_send && !r_rd_pend && (r_idx <= {1'b0, r_len})) begin
                    w_issue = 1'b1;
                    if (r_we && (r_idx[3:0] == r_len)) w_next = ST_RESP;
                end else if (i_en_bus_recv && r_rd_pend && (r_idx == {1'b0, r_len} + 5'd1)) begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_issue) begin
            w_cmd = w_cur_dp ? (w_cur_we ? BUS_DP_WRITE : BUS_DP_READ) : BUS_PC_READ;
            w_nib = w_cur_we ? w_cur_wdata[{w_cur_idx, 2'b00} +: 4] : 4'h0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dp          <= 1'b0;
            r_we          <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_idx         <= '0;
            r_load_cnt    <= '0;
            r_fetch_nib   <= '0;
            r_nib_out     <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_stall       <= 1'b0;
            r_strobe      <= 1'b0;
            r_cmd         <= BUS_NOP;
        end else begin
            r_strobe      <= w_issue || w_load;
            r_cmd         <= w_cmd;
            r_nib_out     <= w_nib;
            r_fetch_valid <= w_finish && !w_cur_dp;
            r_done        <= w_finish && w_cur_dp;
            if (w_accept) begin
                r_dp       <= i_data_req;
                r_we       <= w_cur_we;
                r_addr     <= w_req_addr;
                r_len      <= w_cur_len;
                r_wdata    <= i_data_wdata;
                r_load_cnt <= '0;
                r_idx      <= w_hit ? 5'd1 : 5'd0;
                r_rd_pend  <= w_hit && !w_cur_we;
                r_stall    <= i_data_req && !w_finish;
                if (i_data_req) r_rdata <= '0;
            end else begin
                if (w_load) r_load_cnt <= r_load_cnt + 3'd1;
                if (w_issue) begin
                    r_idx     <= r_idx + 5'd1;
                    r_rd_pend <= !r_we;
                end else if (i_en_bus_recv && r_rd_pend) begin
                    r_rd_pend <= 1'b0;
                    if (r_dp) r_rdata[{w_rd_idx, 2'b00} +: 4] <= i_bus_nibble_in;
                    else      r_fetch_nib                     <= i_bus_nibble_in;
                end
                if (w_finish) r_stall <= 1'b0;
            end
        end
    end

    assign o_fetch_nibble   = r_fetch_nib;
    assign o_fetch_valid    = r_fetch_valid;
    assign o_data_rdata     = r_rdata;
    assign o_data_done      = r_done;
    assign o_stall_dec      = r_stall;
    assign o_bus_strobe     = r_strobe;
    assign o_bus_cmd        = r_cmd;
    assign o_bus_nibble_out = r_nib_out;

endmodule
`default_nettype wire
